// File: rtl/updown_mod_counter.sv
// -----------------------------------------------------------------------------
// updown_mod_counter
//
// Synchronous up/down counter with programmable modulus (0..MAX_VAL),
// parallel load (clamped to MAX_VAL), and 74xx-style cascade enables
// (CEP/CET/TC). WRAP is a registered one-cycle pulse that coincides with Q
// showing the wrapped value.
//
// Chaining: stage n+1 CET = stage n TC, with CEP shared by every stage. This
// gives a synchronous multi-digit counter. With MAX_VAL = 9 each stage is a
// BCD digit.
//
// Optional build macro: UPDOWN_MOD_COUNTER_SAT_EN
//   - Defined: saturating mode.
//     - An up-count at MAX_VAL holds MAX_VAL.
//     - A down-count at 0 holds 0.
//     - WRAP is tied low.
//     - TC still flags the limit.
//   - Undefined (default): wrap-around mode.
// -----------------------------------------------------------------------------
module updown_mod_counter #(
    parameter int unsigned       WIDTH     = 8,
    parameter longint unsigned   MAX_VAL   = (64'd1 << WIDTH) - 64'd1,
    parameter longint unsigned   RESET_VAL = 64'd0
) (
    input  logic             CP,
    input  logic             SR,
    input  logic [WIDTH-1:0] P,
    input  logic             PE,
    input  logic             UD,
    input  logic             CEP,
    input  logic             CET,
    output logic [WIDTH-1:0] Q,
    output logic             TC,
    output logic             WRAP
);

    // Largest value representable in WIDTH bits, held in 64-bit arithmetic
    // so the range checks below do not overflow.
    localparam longint unsigned MAX_LIMIT = (64'd1 << WIDTH) - 64'd1;

    localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] RESET_Q = WIDTH'(RESET_VAL);
    localparam logic [WIDTH-1:0] ONE_Q   = WIDTH'(1);

`ifdef UPDOWN_MOD_COUNTER_SAT_EN
    localparam bit SATURATE = 1'b1;
`else
    localparam bit SATURATE = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Elaboration-time parameter checks
    // -------------------------------------------------------------------------
    generate
        if (WIDTH < 2 || WIDTH > 63) begin : g_bad_width
            $error("updown_mod_counter: WIDTH must be in 2..63");
        end
        if (MAX_VAL < 64'd1 || MAX_VAL > MAX_LIMIT) begin : g_bad_max
            $error("updown_mod_counter: MAX_VAL must be in 1..2**WIDTH-1");
        end
        if (RESET_VAL > MAX_VAL) begin : g_bad_reset
            $error("updown_mod_counter: RESET_VAL must not exceed MAX_VAL");
        end
    endgenerate

    // -------------------------------------------------------------------------
    // State and next-state signals
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] q_next;
    logic             wrap_reg;
    logic             wrap_next;

    logic [WIDTH-1:0] load_val;
    logic             at_max;
    logic             at_zero;
    logic             count_en;

    // Limit detection and the load path; the load clamps out-of-range data.
    assign at_max   = (q_reg == MAX_Q);
    assign at_zero  = (q_reg == '0);
    assign load_val = (P > MAX_Q) ? MAX_Q : P;
    assign count_en = CEP & CET;

    // Next count and wrap flag: load beats count, and count beats hold.
    always_comb begin
        // NOTE: every output of this block gets a default first. A path that
        // leaves a variable unassigned would infer a latch.
        q_next    = q_reg;
        wrap_next = 1'b0;

        if (!PE) begin
            q_next = load_val;
        end else if (count_en) begin
            if (UD) begin
                if (!at_max) begin
                    q_next = q_reg + ONE_Q;
                end else if (!SATURATE) begin
                    q_next    = '0;
                    wrap_next = 1'b1;
                end
            end else begin
                if (!at_zero) begin
                    q_next = q_reg - ONE_Q;
                end else if (!SATURATE) begin
                    q_next    = MAX_Q;
                    wrap_next = 1'b1;
                end
            end
        end
    end

    // State register: synchronous reset overrides load, count and hold.
    always_ff @(posedge CP) begin
        // NOTE: sequential state uses non-blocking assignments. All registers
        // then update from the same pre-edge values, with no order race.
        if (SR) begin
            q_reg    <= RESET_Q;
            wrap_reg <= 1'b0;
        end else begin
            q_reg    <= q_next;
            wrap_reg <= wrap_next;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    // TC is combinational, so it reacts in the same cycle to Q, UD and CET.
    // It ignores CEP, which lets a shared CEP stall a whole chain without
    // disturbing the ripple of TC into the next stage's CET.
    assign Q    = q_reg;
    assign TC   = CET & (UD ? at_max : at_zero);
    assign WRAP = SATURATE ? 1'b0 : wrap_reg;

endmodule

// File: tb/tb_updown_mod_counter.sv
// -----------------------------------------------------------------------------
// tb_updown_mod_counter
//
// Directed bench for updown_mod_counter with WIDTH=4, MAX_VAL=9, RESET_VAL=0.
//   - u_dut exercises these behaviours:
//     - reset
//     - load and clamp
//     - up and down wrap
//     - enable gating
//     - TC timing
//   - u_c0 and u_c1 form a two-digit BCD cascade.
//
// Each expected result is queued as the stimulus is driven. The queue is
// drained and compared once the DUT has responded: #1 after the clock edge,
// or #1 after an input change for the combinational TC.
// Expected values follow UPDOWN_MOD_COUNTER_SAT_EN when it is defined.
// -----------------------------------------------------------------------------
module tb_updown_mod_counter;

`ifdef UPDOWN_MOD_COUNTER_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Single-counter DUT signals
    logic       sr, pe, ud, cep, cet;
    logic [3:0] p;
    logic [3:0] q;
    logic       tc, wrap;

    // Cascade signals
    logic       c_sr, c_cep;
    logic [3:0] q0, q1;
    logic       tc0, tc1, wrap0, wrap1;

    updown_mod_counter #(.WIDTH(4), .MAX_VAL(9), .RESET_VAL(0)) u_dut (
        .CP(clk), .SR(sr), .P(p), .PE(pe), .UD(ud),
        .CEP(cep), .CET(cet), .Q(q), .TC(tc), .WRAP(wrap)
    );

    updown_mod_counter #(.WIDTH(4), .MAX_VAL(9), .RESET_VAL(0)) u_c0 (
        .CP(clk), .SR(c_sr), .P(4'h0), .PE(1'b1), .UD(1'b1),
        .CEP(c_cep), .CET(1'b1), .Q(q0), .TC(tc0), .WRAP(wrap0)
    );

    updown_mod_counter #(.WIDTH(4), .MAX_VAL(9), .RESET_VAL(0)) u_c1 (
        .CP(clk), .SR(c_sr), .P(4'h0), .PE(1'b1), .UD(1'b1),
        .CEP(c_cep), .CET(tc0), .Q(q1), .TC(tc1), .WRAP(wrap1)
    );

    // Scoreboard entries are packed into a 12-bit word:
    //   single counter: {4'h0, Q, 2'b00, TC, WRAP}
    //   cascade:        {Q1, Q0, 2'b00, TC1, TC0}
    typedef struct {
        string       tag;
        bit          cascade;
        logic [11:0] word;
    } exp_t;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    task automatic push_main(input string tag, input logic [3:0] eq,
                             input logic etc, input logic ewrap);
        exp_t e;
        e.tag     = tag;
        e.cascade = 1'b0;
        e.word    = {4'h0, eq, 2'b00, etc, ewrap};
        sb.push_back(e);
    endtask

    task automatic push_casc(input string tag, input logic [3:0] e1,
                             input logic [3:0] e0, input logic etc1,
                             input logic etc0);
        exp_t e;
        e.tag     = tag;
        e.cascade = 1'b1;
        e.word    = {e1, e0, 2'b00, etc1, etc0};
        sb.push_back(e);
    endtask

    // Pop every queued expectation and compare it with the DUT outputs.
    task automatic drain();
        while (sb.size() > 0) begin
            exp_t        e;
            logic [11:0] obs;
            e   = sb.pop_front();
            obs = e.cascade ? {q1, q0, 2'b00, tc1, tc0}
                            : {4'h0, q, 2'b00, tc, wrap};
            n_vec++;
            assert (obs === e.word) else begin
                n_fail++;
                $error("FAIL %s: observed %h expected %h", e.tag, obs, e.word);
            end
        end
    endtask

    // Advance one rising edge, then check #1 later.
    task automatic tick();
        @(posedge clk);
        #1;
        drain();
    endtask

    // Check the combinational response without a clock edge.
    task automatic check_now();
        #1;
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset priority: SR wins over load and count.
        sr = 1'b1; pe = 1'b0; p = 4'd5; ud = 1'b1; cep = 1'b1; cet = 1'b1;
        c_sr = 1'b1; c_cep = 1'b0;
        push_main("reset", 4'd0, 1'b0, 1'b0);
        push_casc("casc_reset", 4'd0, 4'd0, 1'b0, 1'b0);
        tick();

        sr = 1'b0; c_sr = 1'b0;
        push_main("load5", 4'd5, 1'b0, 1'b0);
        tick();

        // Up-count wrap from 7.
        p = 4'd7;
        push_main("load7", 4'd7, 1'b0, 1'b0);
        tick();
        pe = 1'b1;
        push_main("up8", 4'd8, 1'b0, 1'b0);
        tick();
        push_main("up9", 4'd9, 1'b1, 1'b0);
        tick();
        push_main("up_wrap", SAT ? 4'd9 : 4'd0, SAT, !SAT);
        tick();
        push_main("up_after", SAT ? 4'd9 : 4'd1, SAT, 1'b0);
        tick();

        // Load clamp.
        pe = 1'b0; p = 4'd14;
        push_main("clamp14", 4'd9, 1'b1, 1'b0);
        tick();
        p = 4'd15;
        push_main("clamp15", 4'd9, 1'b1, 1'b0);
        tick();

        // Down-count wrap from 1.
        p = 4'd1; ud = 1'b0;
        push_main("load1", 4'd1, 1'b0, 1'b0);
        tick();
        pe = 1'b1;
        push_main("dn0", 4'd0, 1'b1, 1'b0);
        tick();
        push_main("dn_wrap", SAT ? 4'd0 : 4'd9, SAT, !SAT);
        tick();
        push_main("dn_after", SAT ? 4'd0 : 4'd8, SAT, 1'b0);
        tick();

        // Enable gating and TC timing at Q=9.
        pe = 1'b0; p = 4'd9; ud = 1'b1;
        push_main("load9", 4'd9, 1'b1, 1'b0);
        tick();
        pe = 1'b1; cet = 1'b0;
        push_main("cet0_tc", 4'd9, 1'b0, 1'b0);
        check_now();
        push_main("cet0_hold", 4'd9, 1'b0, 1'b0);
        tick();
        cet = 1'b1; cep = 1'b0;
        push_main("cep0_tc", 4'd9, 1'b1, 1'b0);
        check_now();
        push_main("cep0_hold", 4'd9, 1'b1, 1'b0);
        tick();
        ud = 1'b0;
        push_main("ud_flip_tc", 4'd9, 1'b0, 1'b0);
        check_now();
        cep = 1'b1;
        push_main("dn_from9", 4'd8, 1'b0, 1'b0);
        tick();

        // Load ignores the count enables.
        pe = 1'b0; p = 4'd3; cep = 1'b0; cet = 1'b0;
        push_main("load_no_en", 4'd3, 1'b0, 1'b0);
        tick();

        // Mid-run reset wins over a pending load.
        sr = 1'b1; p = 4'd6; cep = 1'b1; cet = 1'b1;
        push_main("sr_mid", 4'd0, 1'b1, 1'b0);
        tick();
        sr = 1'b0;

        // Load 8 and count up three edges. The next hold must clear WRAP.
        ud = 1'b1; p = 4'd8;
        push_main("load8", 4'd8, 1'b0, 1'b0);
        tick();
        pe = 1'b1;
        push_main("l8_up9", 4'd9, 1'b1, 1'b0);
        tick();
        push_main("l8_wrap", SAT ? 4'd9 : 4'd0, SAT, !SAT);
        tick();
        push_main("l8_up_after", SAT ? 4'd9 : 4'd1, SAT, 1'b0);
        tick();
        cep = 1'b0;
        push_main("hold_no_wrap", SAT ? 4'd9 : 4'd1, SAT, 1'b0);
        tick();

        // Two-digit BCD cascade: run 100 edges up from 00.
        c_cep = 1'b1;
        for (int n = 1; n <= 100; n++) begin
            logic [3:0] e0, e1;
            logic       et0, et1;
            e0  = 4'(n % 10);
            e1  = 4'((n / 10) % 10);
            et0 = (e0 == 4'd9);
            et1 = et0 && (e1 == 4'd9);
            push_casc($sformatf("casc_%0d", n), e1, e0, et1, et0);
            tick();
        end
        c_cep = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
